// File: rtl/ram_pkg.sv
// ram_pkg
//   Shared constants for the RAM burst reader slice.
//   - DEFAULT_D_WIDTH / DEFAULT_A_WIDTH : default RAM word and address widths
//   - ST_IDLE / ST_ISSUE / ST_DRAIN     : burst controller state encodings
//   - state_t                           : storage type for the controller state
package ram_pkg;

  localparam int DEFAULT_D_WIDTH = 16;
  localparam int DEFAULT_A_WIDTH = 5;

  typedef logic [1:0] state_t;

  // Plain constants rather than a typed enum so the encoding stays fixed and
  // compatible with older blocks that compare the state against raw values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/ram_rd_skid.sv
// ram_rd_skid
//   Two-entry FIFO that decouples RAM read data from a stalling consumer.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     push, push_data,
//     push_last           : write one word and its end-of-burst tag
//     pop                 : consumer takes the head word
//     count               : occupancy, 0..2
//     out_data, out_last  : head word and tag, forced to zero while empty
module ram_rd_skid #(
  parameter int D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [D_WIDTH-1:0] push_data,
  input  logic               push_last,
  input  logic               pop,
  output logic [1:0]         count,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last
);

  logic [D_WIDTH-1:0] data_mem [2];
  logic               last_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;

  // Storage and pointers. The upstream issue throttle guarantees a push never
  // lands on a full buffer unless a pop happens on the same edge, so no
  // overflow guard is needed here. Push and pop on the same edge touch
  // different slots, which keeps order intact and leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stale entries are masked so the outputs read zero whenever nothing is valid.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (count != 2'd0) begin
      out_data = data_mem[rd_ptr];
      out_last = last_mem[rd_ptr];
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Accepts a (start address, length-1) burst command, reads consecutive words
//   from a synchronous RAM read port (one-cycle read latency) and streams them
//   out over a valid/ready interface, tagging the final word.
//   Ports:
//     clk, rst                     : clock, asynchronous active-high reset
//     cmd_valid, cmd_ready         : command handshake (ready only when idle)
//     cmd_addr, cmd_len            : start address and word count minus one
//     address_read, data_read      : RAM read port (data one edge after address)
//     out_valid, out_ready         : output stream handshake
//     out_data, out_last           : streamed word and end-of-burst marker
//     busy                         : a burst is in progress
module ram_burst_reader
  import ram_pkg::*;
#(
  parameter int D_WIDTH = DEFAULT_D_WIDTH,
  parameter int A_WIDTH = DEFAULT_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [A_WIDTH-1:0] cmd_addr,
  input  logic [A_WIDTH-1:0] cmd_len,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  output logic               busy
);

  localparam logic [A_WIDTH-1:0] ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};

  state_t             state;
  logic [A_WIDTH-1:0] addr;
  logic [A_WIDTH-1:0] counter;
  logic               inflight;
  logic               inflight_last;
  logic [1:0]         fifo_count;
  logic [2:0]         occupancy;
  logic               pop;
  logic               issue;

  assign cmd_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign address_read = addr;
  assign out_valid    = (fifo_count != 2'd0);
  assign pop          = out_valid && out_ready;

  // A read is only launched if its word is guaranteed a FIFO slot when it
  // returns: buffered words plus the one in flight, less the one leaving this
  // edge, must be below two. Written as "occupancy < 2 + pop" to stay unsigned.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign issue     = (state == ST_ISSUE) && (occupancy < (3'd2 + {2'b00, pop}));

  // Burst controller. inflight marks that the RAM is returning a word on the
  // next edge; inflight_last carries the end-of-burst tag alongside it.
  // The counter stops at zero on the final issue instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr          <= '0;
      counter       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (counter == '0);
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr    <= cmd_addr;
            counter <= cmd_len;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            addr <= addr + ONE;
            if (counter == '0) begin
              state <= ST_DRAIN;
            end else begin
              counter <= counter - ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last && !inflight) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Returned RAM words land in the skid buffer one edge after their issue.
  ram_rd_skid #(
    .D_WIDTH (D_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (data_read),
    .push_last (inflight_last),
    .pop       (pop),
    .count     (fifo_count),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader
//   Scoreboard bench: tests push hand-computed expected words, a negedge
//   monitor pops and compares on every output handshake.
module tb_ram_burst_reader;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [AW-1:0] address_read;
  logic [DW-1:0] data_read;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q [$];
  exp_t          exp_item;
  logic [DW-1:0] mem [0:31];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int accept_count = 0;
  int last_accept_edge = 0;
  int last_hs_edge = 0;
  int first_pop_edge = -1;
  int pop_count = 0;
  int accept_edge_a = 0;
  int accept_edge_1 = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  ram_burst_reader #(
    .D_WIDTH (DW),
    .A_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .address_read (address_read),
    .data_read    (data_read),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Synchronous RAM model with one-edge read latency.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
  end

  always @(posedge clk) data_read <= mem[address_read];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic expectWord(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({d, l});
  endtask

  // Records the edge at which each command handshake completes.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      accept_count++;
      last_accept_edge = cycle + 1;
    end
  end

  // Output monitor: scoreboard compare on handshake, stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid_held", 32'(out_valid), 32'd1);
        checkOutput("stall_data_stable", 32'(out_data), 32'(prev_data));
        checkOutput("stall_last_stable", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h expected none", out_data);
        end else begin
          exp_item = exp_q.pop_front();
          checkOutput("word_data", 32'(out_data), 32'(exp_item.data));
          checkOutput("word_last", 32'(out_last), 32'(exp_item.last));
        end
        pop_count++;
        if (first_pop_edge < 0) first_pop_edge = cycle + 1;
        if (out_last) last_hs_edge = cycle + 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Offers a command and waits (bounded) for its handshake edge.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [AW-1:0] l, input bit hold);
    int start;
    bit accepted;
    start = accept_count;
    accepted = 0;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (accept_count != start) begin
        accepted = 1;
        break;
      end
    end
    #1;
    if (!hold) cmd_valid = 1'b0;
    if (!accepted) checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  // Runs until the burst drains and the scoreboard is empty, optionally
  // toggling out_ready every cycle.
  task automatic waitIdle(input bit toggle);
    bit done;
    done = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
      if (toggle) out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    checkOutput("burst_done", 32'(done), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_address_read", 32'(address_read), 32'd0);

    // Basic burst: latency and one word per cycle.
    $display("[TB] burst addr 4 len 3");
    expectWord(16'h1004, 1'b0);
    expectWord(16'h1005, 1'b0);
    expectWord(16'h1006, 1'b0);
    expectWord(16'h1007, 1'b1);
    first_pop_edge = -1;
    applyStimulus(5'd4, 5'd3, 1'b0);
    accept_edge_a = last_accept_edge;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("no_valid_after_E1", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("valid_after_E2", 32'(out_valid), 32'd1);
    waitIdle(1'b0);
    checkOutput("first_pop_edge", 32'(first_pop_edge - accept_edge_a), 32'd3);
    checkOutput("back_to_back_words", 32'(last_hs_edge - first_pop_edge), 32'd3);
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Address wrap-around.
    $display("[TB] burst addr 30 len 3");
    expectWord(16'h101E, 1'b0);
    expectWord(16'h101F, 1'b0);
    expectWord(16'h1000, 1'b0);
    expectWord(16'h1001, 1'b1);
    applyStimulus(5'd30, 5'd3, 1'b0);
    waitIdle(1'b0);

    // Consumer toggling ready every cycle.
    $display("[TB] burst addr 16 len 7 toggled ready");
    for (int i = 0; i < 8; i++) expectWord(16'h1010 + 16'(i), i == 7);
    applyStimulus(5'd16, 5'd7, 1'b0);
    waitIdle(1'b1);

    // Long stall: only two reads may be launched.
    $display("[TB] burst addr 10 len 5 stalled");
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) expectWord(16'h100A + 16'(i), i == 5);
    applyStimulus(5'd10, 5'd5, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stall_address_read", 32'(address_read), 32'd12);
    checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_head_word", 32'(out_data), 32'h100A);
    out_ready = 1'b1;
    waitIdle(1'b0);

    // Reset in the middle of a burst.
    $display("[TB] reset mid burst");
    for (int i = 0; i < 8; i++) expectWord(16'h1000 + 16'(i), i == 7);
    pop_count = 0;
    applyStimulus(5'd0, 5'd7, 1'b0);
    for (int n = 0; n < 50 && pop_count < 2; n++) @(negedge clk);
    checkOutput("two_words_before_reset", 32'(pop_count), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    checkOutput("midrst_out_last", 32'(out_last), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_address_read", 32'(address_read), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_word_after_reset", 32'(out_valid), 32'd0);
    checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);
    expectWord(16'h1000, 1'b1);
    applyStimulus(5'd0, 5'd0, 1'b0);
    waitIdle(1'b0);

    // Command held valid across a burst.
    $display("[TB] held command valid");
    expectWord(16'h1008, 1'b0);
    expectWord(16'h1009, 1'b0);
    expectWord(16'h100A, 1'b1);
    expectWord(16'h1014, 1'b0);
    expectWord(16'h1015, 1'b1);
    applyStimulus(5'd8, 5'd2, 1'b1);
    accept_edge_1 = last_accept_edge;
    applyStimulus(5'd20, 5'd1, 1'b0);
    checkOutput("second_accept_edge", 32'(last_accept_edge - last_hs_edge), 32'd1);
    checkOutput("second_accept_after_first", 32'(last_accept_edge > accept_edge_1), 32'd1);
    waitIdle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
